phase_level_sequencer: RTL and testbench

- Controller ahead of the three-phase multilevel modulator; drives its PhA/PhB/PhC level commands.
- Accepts three-phase target level sets over a valid/ready handshake.
- Moves each phase toward its target in single ±1 level steps, with a programmable minimum dwell between steps.
- Owns enable and fault sequencing: on fault or disable, ramps all phases to level 0 before idling.

---
 rtl/phase_level_sequencer_pkg.sv | 31 +++
 rtl/phase_level_sequencer_phase_stepper.sv | 40 ++++
 rtl/phase_level_sequencer.sv | 141 ++++++++++++++
 tb/tb_phase_level_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_level_sequencer_pkg.sv
// Shared definitions for the three-phase level sequencer: level limits,
// FSM encoding and the target range helpers.
package phase_level_sequencer_pkg;

  localparam int LVL_BITS   = 3;
  localparam int DWELL_BITS = 16;

  localparam int LVL_MAX = 3;
  localparam int LVL_MIN = -3;

  typedef logic signed [LVL_BITS-1:0] level_t;
  typedef logic [DWELL_BITS-1:0]      dwell_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    SHUTDOWN   = 2'd2,
    FAULT_HOLD = 2'd3
  } state_t;

  function automatic logic level_illegal(input int v);
    return (v < LVL_MIN) || (v > LVL_MAX);
  endfunction

  function automatic int clamp_level(input int v);
    if (v < LVL_MIN) return LVL_MIN;
    if (v > LVL_MAX) return LVL_MAX;
    return v;
  endfunction

endpackage

// File: rtl/phase_level_sequencer_phase_stepper.sv
// One phase: current level register plus dwell down-counter; moves the level
// one step toward the target whenever the counter has run out.
module phase_stepper
  import phase_level_sequencer_pkg::*;
#(
  parameter int LVL_W   = LVL_BITS,
  parameter int DWELL_W = DWELL_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_en,
  input  logic signed [LVL_W-1:0]  target,
  input  logic [DWELL_W-1:0]       dwell_cfg,
  output logic signed [LVL_W-1:0]  level,
  output logic                     at_target
);

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] reload;

  // dwell_cfg of 0 behaves as 1: the counter stays at 0 and we step every cycle
  assign reload    = (dwell_cfg == '0) ? '0 : dwell_cfg - 1'b1;
  assign at_target = (level == target);

  // While idle the counter is cleared so a fresh run never inherits a dwell
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
      cnt   <= '0;
    end else if (!step_en) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else if (level != target) begin
      level <= (level < target) ? level + LVL_W'(1) : level - LVL_W'(1);
      cnt   <= reload;
    end
  end

endmodule

// File: rtl/phase_level_sequencer.sv
// Three-phase level sequencer: accepts target level sets, ramps each phase in
// single steps with a minimum dwell, and ramps everything to 0 on fault/disable.
//
//   state      | meaning
//   IDLE       | outputs 0, waiting for en
//   RUN        | accepting targets, phases track their targets
//   SHUTDOWN   | targets forced to 0, waiting for all phases to reach 0
//   FAULT_HOLD | outputs 0, waiting for fault and en both low
module phase_level_sequencer
  import phase_level_sequencer_pkg::*;
#(
  parameter int LVL_W   = LVL_BITS,
  parameter int DWELL_W = DWELL_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     fault,
  input  logic [DWELL_W-1:0]       dwell_cfg,
  input  logic                     tgt_valid,
  output logic                     tgt_ready,
  input  logic signed [LVL_W-1:0]  tgt_a,
  input  logic signed [LVL_W-1:0]  tgt_b,
  input  logic signed [LVL_W-1:0]  tgt_c,
  output logic signed [LVL_W-1:0]  PhA,
  output logic signed [LVL_W-1:0]  PhB,
  output logic signed [LVL_W-1:0]  PhC,
  output logic                     aligned,
  output logic                     err,
  output logic [1:0]               state
);

  state_t state_q, state_d;

  logic signed [LVL_W-1:0] t_a, t_b, t_c;
  logic signed [LVL_W-1:0] ca, cb, cc;
  logic signed [LVL_W-1:0] lvl_a, lvl_b, lvl_c;
  logic                    at_a, at_b, at_c;
  logic                    step_en;
  logic                    accept;
  logic                    bad_tgt;
  logic                    all_zero;
  logic                    enter_shutdown;

  assign ca = LVL_W'(clamp_level(int'(tgt_a)));
  assign cb = LVL_W'(clamp_level(int'(tgt_b)));
  assign cc = LVL_W'(clamp_level(int'(tgt_c)));

  assign bad_tgt = level_illegal(int'(tgt_a)) |
                   level_illegal(int'(tgt_b)) |
                   level_illegal(int'(tgt_c));

  // A stop request in RUN wins over a target offered in the same cycle
  assign accept         = tgt_valid & tgt_ready & en & ~fault;
  assign enter_shutdown = (state_q == RUN) && (state_d == SHUTDOWN);
  assign all_zero       = (lvl_a == '0) && (lvl_b == '0) && (lvl_c == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_a     <= '0;
      t_b     <= '0;
      t_c     <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enter_shutdown) begin
        t_a <= '0;
        t_b <= '0;
        t_c <= '0;
      end else if (accept) begin
        t_a <= ca;
        t_b <= cb;
        t_c <= cc;
      end
      if (accept && bad_tgt) err <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_ready = 1'b0;
    step_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = fault ? FAULT_HOLD : RUN;
      end
      RUN: begin
        tgt_ready = 1'b1;
        step_en   = 1'b1;
        if (fault || !en) state_d = SHUTDOWN;
      end
      SHUTDOWN: begin
        step_en = 1'b1;
        if (all_zero) state_d = fault ? FAULT_HOLD : IDLE;
      end
      FAULT_HOLD: begin
        if (!fault && !en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  phase_stepper #(.LVL_W(LVL_W), .DWELL_W(DWELL_W)) u_step_a (
    .clk       (clk),
    .rst       (rst),
    .step_en   (step_en),
    .target    (t_a),
    .dwell_cfg (dwell_cfg),
    .level     (lvl_a),
    .at_target (at_a)
  );

  phase_stepper #(.LVL_W(LVL_W), .DWELL_W(DWELL_W)) u_step_b (
    .clk       (clk),
    .rst       (rst),
    .step_en   (step_en),
    .target    (t_b),
    .dwell_cfg (dwell_cfg),
    .level     (lvl_b),
    .at_target (at_b)
  );

  phase_stepper #(.LVL_W(LVL_W), .DWELL_W(DWELL_W)) u_step_c (
    .clk       (clk),
    .rst       (rst),
    .step_en   (step_en),
    .target    (t_c),
    .dwell_cfg (dwell_cfg),
    .level     (lvl_c),
    .at_target (at_c)
  );

  // Levels are only nonzero in RUN/SHUTDOWN; SHUTDOWN exits only at all-zero
  assign PhA     = lvl_a;
  assign PhB     = lvl_b;
  assign PhC     = lvl_c;
  assign aligned = at_a & at_b & at_c;
  assign state   = state_q;

endmodule

// File: tb/tb_phase_level_sequencer.sv
// Scoreboard bench for phase_level_sequencer: stimulus queues the expected
// phase steps (edge number and levels); a monitor pops one per observed step.
module tb_phase_level_sequencer;

  logic              clk;
  logic              rst;
  logic              en;
  logic              fault;
  logic [15:0]       dwell_cfg;
  logic              tgt_valid;
  logic              tgt_ready;
  logic signed [2:0] tgt_a, tgt_b, tgt_c;
  logic signed [2:0] pha, phb, phc;
  logic              aligned;
  logic              err;
  logic [1:0]        state;

  typedef struct {
    int edge_n;
    int a;
    int b;
    int c;
  } step_t;

  step_t exp_q[$];
  int    n_total = 0;
  int    n_bad   = 0;
  int    cyc     = 0;
  logic  mon_en  = 1'b1;
  logic [8:0] prev_lv = '0;

  phase_level_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fault     (fault),
    .dwell_cfg (dwell_cfg),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_a     (tgt_a),
    .tgt_b     (tgt_b),
    .tgt_c     (tgt_c),
    .PhA       (pha),
    .PhB       (phb),
    .PhC       (phc),
    .aligned   (aligned),
    .err       (err),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_step(input int e, input int a, input int b, input int c);
    step_t s;
    s.edge_n = e;
    s.a = a;
    s.b = b;
    s.c = c;
    exp_q.push_back(s);
  endtask

  // Monitor: every change of the phase outputs must match the next queued step
  always @(negedge clk) begin
    logic [8:0] cur;
    step_t s;
    cur = {pha, phb, phc};
    if (mon_en && cur != prev_lv) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL step_unexpected: got levels %0d,%0d,%0d at edge %0d, expected no step",
                 int'(pha), int'(phb), int'(phc), cyc);
      end else begin
        s = exp_q.pop_front();
        check("step_edge", cyc, s.edge_n);
        check("step_pha", int'(pha), s.a);
        check("step_phb", int'(phb), s.b);
        check("step_phc", int'(phc), s.c);
      end
    end
    prev_lv = cur;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns the edge number at which the handshake occurred
  task automatic offer(input int a, input int b, input int c, output int k);
    check("ready_at_offer", int'(tgt_ready), 1);
    tgt_a     = 3'(a);
    tgt_b     = 3'(b);
    tgt_c     = 3'(c);
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    k = cyc;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, k3, k4, k5, k6, k7, n;

    rst       = 1'b0;
    en        = 1'b0;
    fault     = 1'b0;
    dwell_cfg = 16'd4;
    tgt_valid = 1'b0;
    tgt_a     = '0;
    tgt_b     = '0;
    tgt_c     = '0;

    #2;
    check("rst_state", int'(state), 0);
    check("rst_pha", int'(pha), 0);
    check("rst_ready", int'(tgt_ready), 0);
    check("rst_err", int'(err), 0);
    check("rst_aligned", int'(aligned), 1);

    // Test 1: basic ramp, dwell 4
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    check("t1_state_run", int'(state), 1);
    offer(3, -3, 0, k);
    check("t1_aligned_after_accept", int'(aligned), 0);
    exp_step(k + 1, 1, -1, 0);
    exp_step(k + 5, 2, -2, 0);
    exp_step(k + 9, 3, -3, 0);
    wait_until(k + 8);
    check("t1_aligned_before", int'(aligned), 0);
    wait_until(k + 9);
    check("t1_aligned_after", int'(aligned), 1);
    wait_until(k + 14);

    // Test 2: ramp reversal mid-dwell
    offer(0, 0, 0, k2);
    exp_step(k2 + 1, 2, -2, 0);
    exp_step(k2 + 5, 1, -1, 0);
    exp_step(k2 + 9, 0, 0, 0);
    wait_until(k2 + 14);
    offer(3, 3, 3, k3);
    exp_step(k3 + 1, 1, 1, 1);
    exp_step(k3 + 5, 2, 2, 2);
    wait_until(k3 + 5);
    check("t2_pha_mid", int'(pha), 2);
    offer(-1, 0, 2, k);
    check("t2_accept_edge", k, k3 + 6);
    exp_step(k3 + 9, 1, 1, 2);
    exp_step(k3 + 13, 0, 0, 2);
    exp_step(k3 + 17, -1, 0, 2);
    wait_until(k3 + 22);
    check("t2_err_clear", int'(err), 0);
    check("t2_aligned", int'(aligned), 1);

    // Test 3: out-of-range target clamps and sets err
    offer(-4, 0, 2, k4);
    check("t3_err_set", int'(err), 1);
    exp_step(k4 + 1, -2, 0, 2);
    exp_step(k4 + 5, -3, 0, 2);
    wait_until(k4 + 10);
    check("t3_pha_clamped", int'(pha), -3);
    check("t3_aligned", int'(aligned), 1);

    // Test 4: dwell 2 ramp through zero, then fault shutdown
    dwell_cfg = 16'd2;
    offer(3, 0, 0, k5);
    exp_step(k5 + 1, -2, 0, 1);
    exp_step(k5 + 3, -1, 0, 0);
    exp_step(k5 + 5, 0, 0, 0);
    exp_step(k5 + 7, 1, 0, 0);
    exp_step(k5 + 9, 2, 0, 0);
    exp_step(k5 + 11, 3, 0, 0);
    wait_until(k5 + 16);
    check("t3_err_sticky", int'(err), 1);
    check("t4_aligned_pre", int'(aligned), 1);
    n = cyc;
    fault = 1'b1;
    exp_step(n + 2, 2, 0, 0);
    exp_step(n + 4, 1, 0, 0);
    exp_step(n + 6, 0, 0, 0);
    wait_until(n + 1);
    check("t4_ready_drop", int'(tgt_ready), 0);
    check("t4_state_shutdown", int'(state), 2);
    wait_until(n + 6);
    check("t4_state_still_shutdown", int'(state), 2);
    wait_until(n + 7);
    check("t4_state_fault_hold", int'(state), 3);
    fault = 1'b0;
    wait_until(n + 10);
    check("t4_hold_with_en", int'(state), 3);
    check("t4_hold_ready", int'(tgt_ready), 0);
    en = 1'b0;
    wait_until(n + 11);
    check("t4_state_idle", int'(state), 0);
    check("t4_err_still_set", int'(err), 1);

    // Test 6: dwell_cfg=0 steps every cycle
    dwell_cfg = 16'd0;
    en = 1'b1;
    @(negedge clk);
    check("t6_state_run", int'(state), 1);
    offer(3, 3, 3, k6);
    exp_step(k6 + 1, 1, 1, 1);
    exp_step(k6 + 2, 2, 2, 2);
    exp_step(k6 + 3, 3, 3, 3);
    wait_until(k6 + 2);
    check("t6_aligned_before", int'(aligned), 0);
    wait_until(k6 + 3);
    check("t6_aligned_after", int'(aligned), 1);
    wait_until(k6 + 6);

    // Test 5: asynchronous reset mid-ramp
    dwell_cfg = 16'd4;
    offer(-3, -3, -3, k7);
    exp_step(k7 + 1, 2, 2, 2);
    exp_step(k7 + 5, 1, 1, 1);
    wait_until(k7 + 6);
    mon_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("t5_pha", int'(pha), 0);
    check("t5_phb", int'(phb), 0);
    check("t5_phc", int'(phc), 0);
    check("t5_state", int'(state), 0);
    check("t5_ready", int'(tgt_ready), 0);
    check("t5_err", int'(err), 0);
    check("t5_aligned", int'(aligned), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("t5_state_run_again", int'(state), 1);
    check("t5_pha_after", int'(pha), 0);

    drain(20);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
